// File: rtl/ruta_datos.sv
// ruta_datos: single-bus register-transfer datapath (A, B, C, T, AC) with an
// add/subtract ALU, sticky bus-conflict flag and a registered completion pulse.
module ruta_datos #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             Ra,
  input  logic             Rb,
  input  logic             Rc,
  input  logic             Rac,
  input  logic             Wa,
  input  logic             Wb,
  input  logic             Wc,
  input  logic             Wt,
  input  logic             Wac,
  input  logic             S,
  input  logic             R,
  input  logic             fin,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] ac_out,
  output logic [WIDTH-1:0] bus,
  output logic             carry,
  output logic             ovf,
  output logic             bus_err,
  output logic             done
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] a_q, b_q, c_q, t_q, ac_q;
  logic             conflict;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             flag_upd;
  logic             carry_n;
  logic             ovf_n;

  // Bus source select; a multi-driver cycle floats the bus to zero
  always_comb begin
    bus      = '0;
    conflict = (Ra & Rb) | (Ra & Rc) | (Ra & Rac) | (Rb & Rc) | (Rb & Rac) | (Rc & Rac);
    case ({Ra, Rb, Rc, Rac})
      4'b1000: bus = a_q;
      4'b0100: bus = b_q;
      4'b0010: bus = c_q;
      4'b0001: bus = ac_q;
      default: bus = '0;
    endcase
  end

  // ALU: T on the left, bus on the right; flags only for a pure add or subtract
  always_comb begin
    sum_w    = {1'b0, t_q} + {1'b0, bus};
    diff_w   = {1'b0, t_q} - {1'b0, bus};
    alu_res  = bus;
    carry_n  = 1'b0;
    ovf_n    = 1'b0;
    flag_upd = Wac & (S ^ R);
    if (S && !R) begin
      alu_res = sum_w[WIDTH-1:0];
      carry_n = sum_w[WIDTH];
      ovf_n   = (t_q[MSB] == bus[MSB]) && (sum_w[MSB] != t_q[MSB]);
    end else if (R && !S) begin
      alu_res = diff_w[WIDTH-1:0];
      carry_n = diff_w[WIDTH];
      ovf_n   = (t_q[MSB] != bus[MSB]) && (diff_w[MSB] != t_q[MSB]);
    end
  end

  // Register file, flags, sticky conflict and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
      ac_q    <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      bus_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= fin;
      if (ld) begin
        a_q     <= a_in;
        b_q     <= b_in;
        c_q     <= c_in;
        t_q     <= '0;
        ac_q    <= '0;
        carry   <= 1'b0;
        ovf     <= 1'b0;
        bus_err <= 1'b0;
      end else if (conflict) begin
        bus_err <= 1'b1;
      end else begin
        if (Wa)  a_q <= bus;
        if (Wb)  b_q <= bus;
        if (Wc)  c_q <= bus;
        if (Wt)  t_q <= bus;
        if (Wac) ac_q <= alu_res;
        if (flag_upd) begin
          carry <= carry_n;
          ovf   <= ovf_n;
        end
      end
    end
  end

  assign a_out  = a_q;
  assign b_out  = b_q;
  assign c_out  = c_q;
  assign ac_out = ac_q;

endmodule

// File: tb/tb_ruta_datos.sv
// tb_ruta_datos: table-driven directed vectors plus hand sequences for reset and done.
module tb_ruta_datos;

  localparam int unsigned W = 8;

  localparam logic [3:0] RD_A  = 4'b1000;
  localparam logic [3:0] RD_B  = 4'b0100;
  localparam logic [3:0] RD_AC = 4'b0001;
  localparam logic [4:0] WR_A  = 5'b10000;
  localparam logic [4:0] WR_B  = 5'b01000;
  localparam logic [4:0] WR_C  = 5'b00100;
  localparam logic [4:0] WR_T  = 5'b00010;
  localparam logic [4:0] WR_AC = 5'b00001;
  localparam logic [1:0] OP_S  = 2'b10;
  localparam logic [1:0] OP_R  = 2'b01;

  logic clk = 1'b0;
  logic reset;
  logic ld;
  logic [W-1:0] a_in, b_in, c_in;
  logic Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wt, Wac, S, R, fin;
  logic [W-1:0] a_out, b_out, c_out, ac_out, bus;
  logic carry, ovf, bus_err, done;

  always #5 clk = ~clk;

  ruta_datos #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ld(ld),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac),
    .Wa(Wa), .Wb(Wb), .Wc(Wc), .Wt(Wt), .Wac(Wac),
    .S(S), .R(R), .fin(fin),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .ac_out(ac_out),
    .bus(bus), .carry(carry), .ovf(ovf), .bus_err(bus_err), .done(done)
  );

  typedef struct {
    logic         ld;
    logic [W-1:0] a, b, c;
    logic [3:0]   rd;
    logic [4:0]   wr;
    logic [1:0]   op;
    logic         fin;
    logic [W-1:0] e_bus, e_a, e_b, e_c, e_ac;
    logic         e_carry, e_ovf, e_err, e_done;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    input logic ld_i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
    input logic [3:0] rd, input logic [4:0] wr, input logic [1:0] op, input logic fn,
    input logic [W-1:0] eb, input logic [W-1:0] ea, input logic [W-1:0] ebb,
    input logic [W-1:0] ec, input logic [W-1:0] eac,
    input logic ecar, input logic eovf, input logic eerr, input logic edone);
    vec_t v;
    v.ld = ld_i; v.a = a; v.b = b; v.c = c; v.rd = rd; v.wr = wr; v.op = op; v.fin = fn;
    v.e_bus = eb; v.e_a = ea; v.e_b = ebb; v.e_c = ec; v.e_ac = eac;
    v.e_carry = ecar; v.e_ovf = eovf; v.e_err = eerr; v.e_done = edone;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ld = v.ld; a_in = v.a; b_in = v.b; c_in = v.c;
    {Ra, Rb, Rc, Rac}     = v.rd;
    {Wa, Wb, Wc, Wt, Wac} = v.wr;
    {S, R}                = v.op;
    fin = v.fin;
  endtask

  task automatic idle();
    ld = 1'b0; a_in = '0; b_in = '0; c_in = '0;
    {Ra, Rb, Rc, Rac} = '0; {Wa, Wb, Wc, Wt, Wac} = '0; {S, R} = '0; fin = 1'b0;
  endtask

  task automatic chk_all_zero(input int idx);
    chk("a_rst", idx, a_out, '0);
    chk("b_rst", idx, b_out, '0);
    chk("c_rst", idx, c_out, '0);
    chk("ac_rst", idx, ac_out, '0);
    chk("bus_rst", idx, bus, '0);
    chk1("carry_rst", idx, carry, 1'b0);
    chk1("ovf_rst", idx, ovf, 1'b0);
    chk1("err_rst", idx, bus_err, 1'b0);
    chk1("done_rst", idx, done, 1'b0);
  endtask

  initial begin
    idle();
    reset = 1'b1;

    // ld   a     b     c     rd          wr                  op         fin  bus   A     B     C     AC    cy ov er dn
    vq.push_back(mk(1, 8'h03, 8'h05, 8'h00, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'h03, 8'h05, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_T, 2'b0, 0, 8'h03, 8'h03, 8'h05, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_AC, OP_S, 0, 8'h03, 8'h03, 8'h05, 8'h00, 8'h06, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_AC, WR_C, 2'b0, 0, 8'h06, 8'h03, 8'h05, 8'h06, 8'h06, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, 4'b0, WR_AC, OP_S, 0, 8'h00, 8'h03, 8'h05, 8'h06, 8'h03, 0, 0, 0, 0));
    // signed overflow on add
    vq.push_back(mk(1, 8'h7F, 8'h01, 8'h00, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_T, 2'b0, 0, 8'h7F, 8'h7F, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_B, WR_AC, OP_S, 0, 8'h01, 8'h7F, 8'h01, 8'h00, 8'h80, 0, 1, 0, 0));
    // unsigned wrap-around on add, flags held across non-ALU transfers
    vq.push_back(mk(1, 8'hFF, 8'h01, 8'h00, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_T, 2'b0, 0, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_B, WR_AC, OP_S, 0, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_B, WR_C, 2'b0, 0, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h00, 1, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_AC, OP_S | OP_R, 0, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'hFF, 1, 0, 0, 0));
    // subtract with borrow, then AC copied into A
    vq.push_back(mk(1, 8'h10, 8'h20, 8'h00, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'h10, 8'h20, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_T, 2'b0, 0, 8'h10, 8'h10, 8'h20, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_B, WR_AC, OP_R, 0, 8'h20, 8'h10, 8'h20, 8'h00, 8'hF0, 1, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_AC, WR_A, 2'b0, 0, 8'hF0, 8'hF0, 8'h20, 8'h00, 8'hF0, 1, 0, 0, 0));
    // signed overflow on subtract
    vq.push_back(mk(1, 8'h80, 8'h01, 8'h00, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_T, 2'b0, 0, 8'h80, 8'h80, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_B, WR_AC, OP_R, 0, 8'h01, 8'h80, 8'h01, 8'h00, 8'h7F, 0, 1, 0, 0));
    // bus conflict: writes suppressed (incl. T), sticky error
    vq.push_back(mk(1, 8'h01, 8'h02, 8'h07, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'h01, 8'h02, 8'h07, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_T, 2'b0, 0, 8'h01, 8'h01, 8'h02, 8'h07, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A | RD_B, WR_C | WR_T | WR_AC, OP_S, 0, 8'h00, 8'h01, 8'h02, 8'h07, 8'h00, 0, 0, 1, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'h01, 8'h02, 8'h07, 8'h00, 0, 0, 1, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, 4'b0, WR_AC, OP_S, 0, 8'h00, 8'h01, 8'h02, 8'h07, 8'h01, 0, 0, 1, 0));
    // ld overrides concurrent strobes and clears the error
    vq.push_back(mk(1, 8'h09, 8'h04, 8'h00, RD_A, WR_C | WR_AC, OP_S, 0, 8'h01, 8'h09, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0));
    // Wt together with Wac: AC uses the old T
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_B, WR_T, 2'b0, 0, 8'h04, 8'h09, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_T | WR_AC, OP_S, 0, 8'h09, 8'h09, 8'h04, 8'h00, 8'h0D, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, 4'b0, WR_AC, OP_S, 0, 8'h00, 8'h09, 8'h04, 8'h00, 8'h09, 0, 0, 0, 0));
    // done follows fin by one clock
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, 4'b0, 5'b0, 2'b0, 1, 8'h00, 8'h09, 8'h04, 8'h00, 8'h09, 0, 0, 0, 1));
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, 4'b0, 5'b0, 2'b0, 0, 8'h00, 8'h09, 8'h04, 8'h00, 8'h09, 0, 0, 0, 0));
    // broadcast write
    vq.push_back(mk(0, 8'h00, 8'h00, 8'h00, RD_A, WR_B | WR_C, 2'b0, 0, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 0, 0, 0, 0));

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero(0);
    reset = 1'b0;

    // vector table
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk("bus", i + 1, bus, vq[i].e_bus);
      @(posedge clk);
      #1;
      chk("a_out", i + 1, a_out, vq[i].e_a);
      chk("b_out", i + 1, b_out, vq[i].e_b);
      chk("c_out", i + 1, c_out, vq[i].e_c);
      chk("ac_out", i + 1, ac_out, vq[i].e_ac);
      chk1("carry", i + 1, carry, vq[i].e_carry);
      chk1("ovf", i + 1, ovf, vq[i].e_ovf);
      chk1("bus_err", i + 1, bus_err, vq[i].e_err);
      chk1("done", i + 1, done, vq[i].e_done);
    end

    // asynchronous reset mid-operation
    @(negedge clk);
    idle(); ld = 1'b1; a_in = 8'h55; fin = 1'b1;
    @(posedge clk);
    #1;
    chk("a_pre_rst", 100, a_out, 8'h55);
    chk1("done_pre_rst", 100, done, 1'b1);
    @(negedge clk);
    idle(); Ra = 1'b1; Rb = 1'b1; fin = 1'b1;
    @(posedge clk);
    #1;
    chk1("err_pre_rst", 101, bus_err, 1'b1);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero(102);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero(103);

    // fin held for one cycle gives a single done pulse one clock later
    @(negedge clk);
    fin = 1'b1;
    #1;
    chk1("done_early", 104, done, 1'b0);
    @(posedge clk);
    #1;
    chk1("done_pulse", 105, done, 1'b1);
    @(negedge clk);
    fin = 1'b0;
    @(posedge clk);
    #1;
    chk1("done_end", 106, done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
